// File: rtl/mmio_stream_rx_core.sv
// Stream-to-MMIO receive slot: fabric words enter a FIFO via valid/ready, the processor drains it by register access.
// Optional threshold interrupt enabled by defining MMIO_STREAM_RX_IRQ_EN.
module mmio_stream_rx_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              irq
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [4:0] REG_DATA   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_POP    = 5'd2;
    localparam logic [4:0] REG_CTRL   = 5'd3;
    localparam logic [4:0] REG_THRESH = 5'd4;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;

    logic full, empty, bus_wr, push, pop, flush, clr_ovf;
    logic [31:0] status;
    logic [31:0] thresh_rd;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign s_ready = !full;
    assign bus_wr  = cs && write;
    assign push    = s_valid && !full;
    assign pop     = bus_wr && (addr == REG_POP) && !empty;
    assign flush   = bus_wr && (addr == REG_CTRL) && wr_data[0];
    assign clr_ovf = bus_wr && (addr == REG_CTRL) && wr_data[1];

    // Storage has no reset so it maps onto distributed RAM; flushed words are simply unreachable.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr_reg] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                if (push && !pop)
                    count_reg <= count_reg + (ADDR_W+1)'(1);
                else if (pop && !push)
                    count_reg <= count_reg - (ADDR_W+1)'(1);
            end
            // A new back-pressure event outranks a simultaneous clear.
            if (s_valid && full)
                overflow_reg <= 1'b1;
            else if (clr_ovf)
                overflow_reg <= 1'b0;
        end
    end

`ifdef MMIO_STREAM_RX_IRQ_EN
    logic [ADDR_W:0] thresh_reg;
    logic            irq_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_reg <= (ADDR_W+1)'(1);
            irq_reg    <= 1'b0;
        end else begin
            if (bus_wr && (addr == REG_THRESH))
                thresh_reg <= (wr_data > 32'(DEPTH)) ? DEPTH_C : wr_data[ADDR_W:0];
            irq_reg <= (thresh_reg != '0) && (count_reg >= thresh_reg);
        end
    end

    assign irq       = irq_reg;
    assign thresh_rd = 32'(thresh_reg);
`else
    assign irq       = 1'b0;
    assign thresh_rd = '0;
`endif

    always_comb begin
        status             = '0;
        status[0]          = empty;
        status[1]          = full;
        status[2]          = overflow_reg;
        status[8+ADDR_W:8] = count_reg;
    end

    always_comb begin
        rd_data = '0;
        if (cs && read) begin
            case (addr)
                REG_DATA:   rd_data = empty ? 32'd0 : 32'(mem[rd_ptr_reg]);
                REG_STATUS: rd_data = status;
                REG_THRESH: rd_data = thresh_rd;
                default:    rd_data = '0;
            endcase
        end
    end

    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;
endmodule

// File: doc/mmio_stream_rx_core.md
Name: mmio_stream_rx_core

Overview:
- MMIO slot responder that sits on the MMIO bus between the slot decoder and a fabric-side streaming producer.
- Fabric pushes words through a valid/ready handshake into an internal FIFO.
- Processor drains the FIFO via MMIO register reads and writes.
- Complements the processor-to-MMIO path: this carries data from hardware to processor.

Parameters:
- DATA_W, 32, stream word width (1..32); narrower words are zero-extended on read.
- ADDR_W, 4, FIFO address bits; depth = 2**ADDR_W = 16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- cs  input  1  slot select from MMIO decoder
- read  input  1  read strobe
- write  input  1  write strobe
- addr  input  5  register index (word address within slot)
- wr_data  input  32  write data
- rd_data  output  32  read data, combinational from registered state
- s_data  input  DATA_W  stream word
- s_valid  input  1  stream word valid
- s_ready  output  1  core can accept word (= !full)
- irq  output  1  threshold interrupt (only with optional feature; otherwise tied 0)

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset clears:
  - wr_ptr, rd_ptr, count = 0
  - overflow = 0
  - threshold = 1
  - irq = 0
  - s_ready = 1 after reset release
- Bus access:
  - Bus is single-cycle with no wait states. rd_data is valid in the same cycle as cs&&read.
  - A write takes effect at the rising edge where cs&&write.
  - Reads have no side effects.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map (addr):
  - 0 DATA (R): FIFO head, zero-extended; returns 0 when empty.
  - 1 STATUS (R):
    - bit0 empty, bit1 full, bit2 overflow
    - bits[8+ADDR_W:8] count (0..16)
    - other bits 0
  - 2 POP (W): any value pops the head if not empty; no effect when empty.
  - 3 CTRL (W):
    - bit0 = flush: ptrs and count to 0
    - bit1 = clear overflow
  - 4 THRESH (R/W): bits[ADDR_W:0]; exists only with the optional feature, otherwise reads 0.
- Stream push:
  - Word is accepted at an edge with s_valid && s_ready.
  - s_ready = !full, registered-state derived with no combinational path from s_valid.
- Overflow:
  - Set when s_valid && full at an edge; sticky until CTRL bit1.
  - The producer is expected to hold the word; overflow flags the back-pressure event only.
- FIFO:
  - Pointers wrap modulo depth.
  - count is ADDR_W+1 bits; full when count == 2**ADDR_W, empty when count == 0.
- Simultaneous events:
  - Push + pop, non-empty: count unchanged, both pointers advance.
  - Push + pop, empty: push accepted, pop ignored; count becomes 1.
  - Flush + push in the same cycle: flush wins and the accepted word is discarded.
  - Flush + pop: flush wins.
  - Clear-overflow + new overflow event in the same cycle: overflow remains 1.
- Reset mid-operation: all state cleared immediately (async); FIFO contents are undefined but unreachable.

Optional Feature:
- Macro: MMIO_STREAM_RX_IRQ_EN.
- Defined:
  - THRESH register exists.
  - irq is a registered output, high when count >= threshold && threshold != 0.
  - Level-sensitive; updates one cycle after count/threshold change.
  - Writes of values > depth are saturated to depth.
- Undefined:
  - irq tied 0; THRESH reads 0 and ignores writes.
  - No threshold flops are synthesised.

Test Plan:
- Reset, then push 0xA5 with s_valid=1 for one cycle -> STATUS reads count=1, empty=0; DATA reads 0x000000A5; POP write -> STATUS empty=1, DATA=0.
- Push 16 words 0..15 back-to-back -> s_ready falls after the 16th; STATUS full=1, count=16; s_valid held high one more cycle -> overflow=1; 16 POP/DATA pairs return 0..15 in order across the pointer wrap.
- FIFO count=3, push and POP in the same cycle -> count stays 3, head advances; on empty FIFO push+POP -> count=1, head = pushed word.
- FIFO count=5, CTRL=0x1 written with s_valid=1 -> count=0, empty=1, word dropped; CTRL=0x2 -> overflow clears; read of addr 7 -> 0.
- MMIO_STREAM_RX_IRQ_EN defined: THRESH=4, push 3 words -> irq=0; 4th word -> irq=1 the next cycle; POP -> irq=0 the next cycle; THRESH=0 -> irq=0.
- Assert reset_n low mid-burst with count=9 -> asynchronously count=0, s_ready=1 after release, overflow=0, irq=0.
